// File: rtl/pc_unit.sv
// Instruction-pointer unit: sequential advance, conditional branches and a
// circular return-address stack with sticky overflow/underflow reporting.
module pc_unit #(
  parameter int unsigned AW        = 16,
  parameter int unsigned RAS_DEPTH = 4,
  parameter int unsigned RESET_PC  = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          adv,
  input  logic          stall,
  input  logic          instr_long,
  input  logic          br_en,
  input  logic [3:0]    br_cond,
  input  logic [AW-1:0] br_target,
  input  logic          call,
  input  logic          ret,
  input  logic          flag_zero,
  input  logic          flag_sign,
  input  logic          flag_carry,
  input  logic          flag_overflow,
  input  logic          busy,
  output logic [AW-1:0] pc,
  output logic [AW-1:0] pc_plus1,
  output logic          taken,
  output logic          ras_empty,
  output logic          ras_full,
  output logic          ras_err
);

  localparam int unsigned PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int unsigned CW = PW + 1;

  logic [AW-1:0] pc_q, pc_d;
  logic [PW-1:0] top_q, top_d;
  logic [CW-1:0] count_q, count_d;
  logic          err_q, err_d;
  logic [AW-1:0] stack_q [RAS_DEPTH];

  logic          cond_true;
  logic          upd;
  logic          do_pop;
  logic          do_push;
  logic [AW-1:0] seq_pc;
  logic [PW-1:0] push_idx;

  always_comb begin
    cond_true = 1'b0;
    unique case (br_cond)
      4'b0000: cond_true = 1'b1;
      4'b0001: cond_true = flag_zero;
      4'b0010: cond_true = !flag_zero;
      4'b0011: cond_true = (flag_sign == flag_overflow);
      4'b0100: cond_true = flag_zero | (flag_sign ^ flag_overflow);
      4'b0101: cond_true = !flag_zero & (flag_sign == flag_overflow);
      4'b0110: cond_true = flag_sign ^ flag_overflow;
      4'b0111: cond_true = flag_overflow;
      4'b1000: cond_true = busy;
      4'b1001: cond_true = flag_sign;
      4'b1010: cond_true = !flag_sign;
      4'b1011: cond_true = !flag_carry;
      4'b1100: cond_true = flag_zero | flag_carry;
      4'b1101: cond_true = !(flag_zero | flag_carry);
      4'b1110: cond_true = flag_carry;
      default: cond_true = !flag_overflow;
    endcase
  end

  assign taken     = br_en & cond_true;
  assign ras_empty = (count_q == '0);
  assign ras_full  = (count_q == CW'(RAS_DEPTH));
  assign ras_err   = err_q;
  assign pc        = pc_q;
  assign pc_plus1  = pc_q + AW'(1);

  assign upd      = adv & !stall;
  assign seq_pc   = pc_q + (instr_long ? AW'(2) : AW'(1));
  assign do_pop   = upd & ret & !ras_empty;
  assign do_push  = upd & taken & call & !ret;
  assign push_idx = top_q + PW'(1);

  // A push onto a full stack lands on the oldest slot, so occupancy saturates.
  always_comb begin
    pc_d    = pc_q;
    top_d   = top_q;
    count_d = count_q;
    err_d   = err_q;
    if (upd) begin
      if (do_pop) begin
        pc_d    = stack_q[top_q];
        top_d   = top_q - PW'(1);
        count_d = count_q - CW'(1);
      end else if (taken) begin
        pc_d = br_target;
      end else begin
        pc_d = seq_pc;
      end
      if (do_push) begin
        top_d = push_idx;
        if (ras_full) err_d = 1'b1;
        else          count_d = count_q + CW'(1);
      end
      if (ret && ras_empty) err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= AW'(RESET_PC);
      top_q   <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      top_q   <= top_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) stack_q[push_idx] <= seq_pc;
  end

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: a queue-based reference model predicts each
// cycle's outcome and a monitor compares it after the following clock edge.
module tb_pc_unit;

  localparam int AW    = 16;
  localparam int DEPTH = 4;
  localparam logic [15:0] RST_PC = 16'h0000;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          adv, stall, instrLong, brEn, call, ret;
  logic [3:0]    brCond;
  logic [AW-1:0] brTarget;
  logic          fZ, fS, fC, fO, busy;
  logic [AW-1:0] pc, pcPlus1;
  logic          taken, rasEmpty, rasFull, rasErr;

  pc_unit #(.AW(AW), .RAS_DEPTH(DEPTH), .RESET_PC(0)) dut (
    .clk(clk), .rst_n(rst_n), .adv(adv), .stall(stall), .instr_long(instrLong),
    .br_en(brEn), .br_cond(brCond), .br_target(brTarget), .call(call), .ret(ret),
    .flag_zero(fZ), .flag_sign(fS), .flag_carry(fC), .flag_overflow(fO), .busy(busy),
    .pc(pc), .pc_plus1(pcPlus1), .taken(taken), .ras_empty(rasEmpty),
    .ras_full(rasFull), .ras_err(rasErr)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          adv, stall, lng, brEn, call, ret, busy;
    logic [3:0]  cond;
    logic [15:0] tgt;
    logic [3:0]  flags;
  } stim_t;

  typedef struct {
    logic [15:0] pc, pcPlus1;
    bit          taken, empty, full, err;
  } exp_t;

  exp_t        expQ[$];
  int          vecCount  = 0;
  int          missCount = 0;

  logic [15:0] mPc;
  logic [15:0] mRas[$];
  bit          mErr;

  function automatic bit condTrue(input logic [3:0] c, input logic [3:0] f, input bit b);
    bit z, s, cy, o;
    {z, s, cy, o} = f;
    case (c)
      4'd0:  return 1'b1;
      4'd1:  return z;
      4'd2:  return !z;
      4'd3:  return s == o;
      4'd4:  return z || (s != o);
      4'd5:  return !z && (s == o);
      4'd6:  return s != o;
      4'd7:  return o;
      4'd8:  return b;
      4'd9:  return s;
      4'd10: return !s;
      4'd11: return !cy;
      4'd12: return z || cy;
      4'd13: return !(z || cy);
      4'd14: return cy;
      default: return !o;
    endcase
  endfunction

  function automatic stim_t idleStim();
    stim_t s;
    s.adv = 1'b1; s.stall = 1'b0; s.lng = 1'b0; s.brEn = 1'b0; s.call = 1'b0;
    s.ret = 1'b0; s.busy = 1'b0; s.cond = 4'd0; s.tgt = 16'h0; s.flags = 4'd0;
    return s;
  endfunction

  task automatic modelReset();
    mPc = RST_PC;
    mRas.delete();
    mErr = 1'b0;
  endtask

  task automatic driveInputs(input stim_t s);
    adv = s.adv; stall = s.stall; instrLong = s.lng; brEn = s.brEn; call = s.call;
    ret = s.ret; busy = s.busy; brCond = s.cond; brTarget = s.tgt;
    {fZ, fS, fC, fO} = s.flags;
  endtask

  // Drive one cycle's inputs and queue what the design should show after the edge.
  task automatic applyStimulus(input stim_t s);
    exp_t        e;
    bit          tk;
    logic [15:0] seqPc;
    @(negedge clk);
    driveInputs(s);
    tk    = s.brEn && condTrue(s.cond, s.flags, s.busy);
    seqPc = mPc + (s.lng ? 16'd2 : 16'd1);
    if (s.adv && !s.stall) begin
      if (s.ret && mRas.size() > 0) begin
        mPc = mRas.pop_back();
      end else begin
        if (s.ret) mErr = 1'b1;
        if (tk && s.call && !s.ret) begin
          if (mRas.size() == DEPTH) begin
            void'(mRas.pop_front());
            mErr = 1'b1;
          end
          mRas.push_back(seqPc);
        end
        mPc = tk ? s.tgt : seqPc;
      end
    end
    e.pc      = mPc;
    e.pcPlus1 = mPc + 16'd1;
    e.taken   = tk;
    e.empty   = (mRas.size() == 0);
    e.full    = (mRas.size() == DEPTH);
    e.err     = mErr;
    expQ.push_back(e);
  endtask

  task automatic checkOutput(input string name, input exp_t e);
    vecCount++;
    if (pc !== e.pc || pcPlus1 !== e.pcPlus1 || taken !== e.taken ||
        rasEmpty !== e.empty || rasFull !== e.full || rasErr !== e.err) begin
      missCount++;
      $display("[TB] FAIL %s: got pc=%h p1=%h tk=%b e=%b f=%b err=%b, want pc=%h p1=%h tk=%b e=%b f=%b err=%b",
               name, pc, pcPlus1, taken, rasEmpty, rasFull, rasErr,
               e.pc, e.pcPlus1, e.taken, e.empty, e.full, e.err);
    end
  endtask

  task automatic checkResetState(input string name);
    vecCount++;
    if (pc !== RST_PC || rasEmpty !== 1'b1 || rasFull !== 1'b0 || rasErr !== 1'b0) begin
      missCount++;
      $display("[TB] FAIL %s: got pc=%h e=%b f=%b err=%b, want pc=%h e=1 f=0 err=0",
               name, pc, rasEmpty, rasFull, rasErr, RST_PC);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput("cycle", e);
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] timeout");
  end

  initial begin : driver
    stim_t s;
    rst_n = 1'b0;
    driveInputs(idleStim());
    adv = 1'b0;
    modelReset();
    #23;
    checkResetState("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // sequential advance 0 -> 1 -> 3 -> 4
    foreach (s.flags[i]) ;
    s = idleStim(); s.lng = 1'b0; applyStimulus(s);
    s.lng = 1'b1; applyStimulus(s);
    s.lng = 1'b0; applyStimulus(s);

    for (int c = 0; c < 16; c++) begin
      for (int f = 0; f < 16; f++) begin
        for (int b = 0; b < ((c == 8) ? 2 : 1); b++) begin
          s = idleStim(); s.brEn = 1'b1; s.cond = 4'(c); s.flags = 4'(f);
          s.busy = bit'(b); s.tgt = 16'h0040;
          applyStimulus(s);
        end
      end
    end

    // call from 0x10 to 0x80, walk to 0x85, return to 0x12
    s = idleStim(); s.brEn = 1'b1; s.tgt = 16'h0010; applyStimulus(s);
    s = idleStim(); s.brEn = 1'b1; s.tgt = 16'h0080; s.call = 1'b1; s.lng = 1'b1;
    applyStimulus(s);
    for (int i = 0; i < 5; i++) applyStimulus(idleStim());
    s = idleStim(); s.ret = 1'b1; applyStimulus(s);

    // overflow then underflow
    for (int i = 0; i < 5; i++) begin
      s = idleStim(); s.brEn = 1'b1; s.call = 1'b1; s.tgt = 16'h0100 + 16'(i * 16);
      applyStimulus(s);
    end
    for (int i = 0; i < 5; i++) begin
      s = idleStim(); s.ret = 1'b1; applyStimulus(s);
    end

    // call and ret together: ret wins, no push
    s = idleStim(); s.brEn = 1'b1; s.call = 1'b1; s.ret = 1'b1; s.tgt = 16'h0300;
    applyStimulus(s);

    // stall at the top of the address space, then wrap
    s = idleStim(); s.brEn = 1'b1; s.tgt = 16'hFFFF; applyStimulus(s);
    for (int i = 0; i < 3; i++) begin
      s = idleStim(); s.lng = 1'b1; s.stall = 1'b1; applyStimulus(s);
    end
    s = idleStim(); s.lng = 1'b1; applyStimulus(s);

    for (int i = 0; i < 400; i++) begin
      s.adv   = ($urandom_range(3) != 0);
      s.stall = ($urandom_range(7) == 0);
      s.lng   = $urandom_range(1) == 1;
      s.brEn  = $urandom_range(1) == 1;
      s.cond  = 4'($urandom_range(15));
      s.tgt   = 16'($urandom);
      s.call  = ($urandom_range(2) == 0);
      s.ret   = ($urandom_range(4) == 0);
      s.flags = 4'($urandom_range(15));
      s.busy  = $urandom_range(1) == 1;
      applyStimulus(s);
    end

    // asynchronous reset between edges while a call is presented
    s = idleStim(); s.brEn = 1'b1; s.call = 1'b1; s.tgt = 16'h0200;
    applyStimulus(s);
    @(negedge clk);
    driveInputs(s);
    #2 rst_n = 1'b0;
    #1 checkResetState("midReset");
    modelReset();
    @(negedge clk);
    adv = 1'b0;
    rst_n = 1'b1;
    s = idleStim(); s.ret = 1'b1; applyStimulus(s);
    applyStimulus(idleStim());

    for (int i = 0; i < 20 && expQ.size() > 0; i++) @(posedge clk);
    #2;
    vecCount++;
    if (expQ.size() != 0) begin
      missCount++;
      $display("[TB] FAIL drain: got %0d pending, want 0", expQ.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
